// File: rtl/cc_branch_unit.sv
// Condition-code back end: holds {N,Z,C,V}, feeds C back to the ALU as Ci,
// resolves conditional branches and sequences the delay slot / annul state.
module cc_branch_unit #(
    parameter bit         BYPASS   = 1'b1,
    parameter logic [3:0] RESET_CC = 4'b0000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inst_valid,
    input  logic       stall,
    input  logic       cc_we,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       br_valid,
    input  logic [3:0] cond,
    input  logic       annul_bit,
    output logic       psr_n,
    output logic       psr_z,
    output logic       psr_c,
    output logic       psr_v,
    output logic       carry_out,
    output logic       branch_taken,
    output logic       annul,
    output logic       dslot
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSLOT = 2'd1,
        ANNUL = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] psr;        // {N,Z,C,V}
    logic [3:0] alu_flags;  // {N,Z,C,V}
    logic [3:0] ev_flags;
    logic       issue;
    logic       squash;
    logic       use_alu;
    logic       ev_n, ev_z, ev_c, ev_v;
    logic       cond_base;
    logic       taken;
    logic       annul_next;

    assign alu_flags = {alu_n, alu_z, alu_c, alu_v};
    assign issue     = inst_valid & ~stall;
    // An instruction issuing while in ANNUL is the squashed delay slot.
    assign squash    = (state == ANNUL);

    // A cc-writing branch sees its own ALU flags only when bypass is enabled.
    assign use_alu   = BYPASS & cc_we & br_valid;
    assign ev_flags  = use_alu ? alu_flags : psr;
    assign {ev_n, ev_z, ev_c, ev_v} = ev_flags;

    // Low three bits pick the base test; cond[3] inverts it, which also turns
    // "never" (0000) into "always" (1000).
    always_comb begin
        cond_base = 1'b0;
        case (cond[2:0])
            3'd0: cond_base = 1'b0;
            3'd1: cond_base = ev_z;
            3'd2: cond_base = ev_z | (ev_n ^ ev_v);
            3'd3: cond_base = ev_n ^ ev_v;
            3'd4: cond_base = ev_c | ev_z;
            3'd5: cond_base = ev_c;
            3'd6: cond_base = ev_n;
            3'd7: cond_base = ev_v;
            default: cond_base = 1'b0;
        endcase
    end

    assign taken      = cond_base ^ cond[3];
    // Branch-always with the a-bit still annuls its slot.
    assign annul_next = annul_bit & (~taken | (cond == 4'b1000));

    // Flags, slot state and the taken pulse all advance only on an issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psr          <= RESET_CC;
            state        <= IDLE;
            branch_taken <= 1'b0;
        end else begin
            branch_taken <= 1'b0;
            if (issue) begin
                if (squash) begin
                    state <= IDLE;
                end else begin
                    if (cc_we)
                        psr <= alu_flags;
                    if (br_valid) begin
                        branch_taken <= taken;
                        state        <= annul_next ? ANNUL : DSLOT;
                    end else begin
                        state <= IDLE;
                    end
                end
            end
        end
    end

    assign {psr_n, psr_z, psr_c, psr_v} = psr;
    assign carry_out = psr[1];
    assign annul     = (state == ANNUL);
    assign dslot     = (state == DSLOT);

endmodule

// File: tb/tb_cc_branch_unit.sv
// Directed bench for cc_branch_unit: a vector table for the issue sequencing,
// hand sequences for bypass, stall-in-annul and async reset, and a full
// condition sweep. A BYPASS=0 copy runs alongside on the same inputs.
module tb_cc_branch_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       inst_valid, stall, cc_we, br_valid, annul_bit;
    logic [3:0] alu;    // {N,Z,C,V}
    logic [3:0] cond;

    logic psr_n, psr_z, psr_c, psr_v, carry_out, branch_taken, annul, dslot;
    logic nb_n, nb_z, nb_c, nb_v, nb_carry, nb_taken, nb_annul, nb_dslot;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cc_branch_unit #(.BYPASS(1'b1), .RESET_CC(4'b0000)) dut (
        .clk(clk), .reset_n(reset_n), .inst_valid(inst_valid), .stall(stall),
        .cc_we(cc_we), .alu_n(alu[3]), .alu_z(alu[2]), .alu_c(alu[1]), .alu_v(alu[0]),
        .br_valid(br_valid), .cond(cond), .annul_bit(annul_bit),
        .psr_n(psr_n), .psr_z(psr_z), .psr_c(psr_c), .psr_v(psr_v),
        .carry_out(carry_out), .branch_taken(branch_taken), .annul(annul), .dslot(dslot)
    );

    cc_branch_unit #(.BYPASS(1'b0), .RESET_CC(4'b0000)) dut_nb (
        .clk(clk), .reset_n(reset_n), .inst_valid(inst_valid), .stall(stall),
        .cc_we(cc_we), .alu_n(alu[3]), .alu_z(alu[2]), .alu_c(alu[1]), .alu_v(alu[0]),
        .br_valid(br_valid), .cond(cond), .annul_bit(annul_bit),
        .psr_n(nb_n), .psr_z(nb_z), .psr_c(nb_c), .psr_v(nb_v),
        .carry_out(nb_carry), .branch_taken(nb_taken), .annul(nb_annul), .dslot(nb_dslot)
    );

    typedef struct packed {
        logic       iv, st, we;
        logic [3:0] alu;
        logic       br;
        logic [3:0] c;
        logic       ab;
        logic [3:0] psr;
        logic       t, an, ds;
    } vec_t;

    vec_t tbl [21];

    // Observed {psr, carry_out, taken, annul, dslot} of the bypass DUT.
    function automatic logic [7:0] obs();
        return {psr_n, psr_z, psr_c, psr_v, carry_out, branch_taken, annul, dslot};
    endfunction

    // Reference condition table, one entry per cond encoding.
    function automatic logic exp_taken(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b1000: return 1'b1;
            4'b0000: return 1'b0;
            4'b0001: return z;
            4'b1001: return !z;
            4'b0010: return z || (n != v);
            4'b1010: return !(z || (n != v));
            4'b0011: return n != v;
            4'b1011: return n == v;
            4'b0100: return cy || z;
            4'b1100: return !(cy || z);
            4'b0101: return cy;
            4'b1101: return !cy;
            4'b0110: return n;
            4'b1110: return !n;
            4'b0111: return v;
            default: return !v;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; return just after the rising edge.
    task automatic drive(input logic iv, input logic st, input logic we, input logic [3:0] a,
                         input logic br, input logic [3:0] c, input logic ab);
        @(negedge clk);
        inst_valid = iv; stall = st; cc_we = we; alu = a;
        br_valid = br; cond = c; annul_bit = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        inst_valid = 1'b0; stall = 1'b0; cc_we = 1'b0; alu = 4'b0;
        br_valid = 1'b0; cond = 4'b0; annul_bit = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        inst_valid = 1'b0; stall = 1'b0; cc_we = 1'b0; alu = 4'b0;
        br_valid = 1'b0; cond = 4'b0; annul_bit = 1'b0;
        //            iv st we alu    br c      ab psr     t  an ds
        tbl[0]  = '{1'b1,1'b0,1'b1,4'b0100,1'b0,4'b0000,1'b0,4'b0100,1'b0,1'b0,1'b0}; // SUBcc z=1
        tbl[1]  = '{1'b1,1'b0,1'b0,4'b0000,1'b1,4'b0001,1'b0,4'b0100,1'b1,1'b0,1'b1}; // BE taken
        tbl[2]  = '{1'b1,1'b0,1'b0,4'b0000,1'b0,4'b0000,1'b0,4'b0100,1'b0,1'b0,1'b0}; // slot -> IDLE
        tbl[3]  = '{1'b1,1'b0,1'b0,4'b0000,1'b1,4'b1001,1'b1,4'b0100,1'b0,1'b1,1'b0}; // BNE,a untaken
        tbl[4]  = '{1'b1,1'b0,1'b1,4'b0010,1'b1,4'b1000,1'b0,4'b0100,1'b0,1'b0,1'b0}; // squashed
        tbl[5]  = '{1'b1,1'b0,1'b0,4'b0000,1'b1,4'b1000,1'b1,4'b0100,1'b1,1'b1,1'b0}; // BA,a
        tbl[6]  = '{1'b1,1'b0,1'b0,4'b0000,1'b0,4'b0000,1'b0,4'b0100,1'b0,1'b0,1'b0}; // squashed
        tbl[7]  = '{1'b1,1'b0,1'b0,4'b0000,1'b1,4'b0000,1'b0,4'b0100,1'b0,1'b0,1'b1}; // BN
        tbl[8]  = '{1'b1,1'b0,1'b0,4'b0000,1'b1,4'b0100,1'b0,4'b0100,1'b1,1'b0,1'b1}; // BLEU in slot
        tbl[9]  = '{1'b1,1'b0,1'b0,4'b0000,1'b1,4'b0000,1'b1,4'b0100,1'b0,1'b1,1'b0}; // BN,a in slot
        tbl[10] = '{1'b1,1'b0,1'b0,4'b0000,1'b0,4'b0000,1'b0,4'b0100,1'b0,1'b0,1'b0}; // squashed
        tbl[11] = '{1'b1,1'b0,1'b1,4'b1000,1'b1,4'b0011,1'b0,4'b1000,1'b1,1'b0,1'b1}; // cc+BL bypass
        tbl[12] = '{1'b1,1'b0,1'b0,4'b0000,1'b0,4'b0000,1'b0,4'b1000,1'b0,1'b0,1'b0};
        tbl[13] = '{1'b1,1'b0,1'b1,4'b0001,1'b0,4'b0000,1'b0,4'b0001,1'b0,1'b0,1'b0}; // v=1
        tbl[14] = '{1'b1,1'b0,1'b0,4'b0000,1'b1,4'b1011,1'b1,4'b0001,1'b0,1'b1,1'b0}; // BGE,a untaken
        tbl[15] = '{1'b1,1'b0,1'b0,4'b0000,1'b0,4'b0000,1'b0,4'b0001,1'b0,1'b0,1'b0};
        tbl[16] = '{1'b0,1'b0,1'b1,4'b1111,1'b1,4'b1000,1'b0,4'b0001,1'b0,1'b0,1'b0}; // no valid
        tbl[17] = '{1'b1,1'b1,1'b1,4'b1111,1'b1,4'b1000,1'b0,4'b0001,1'b0,1'b0,1'b0}; // stalled
        tbl[18] = '{1'b1,1'b0,1'b0,4'b0000,1'b1,4'b1000,1'b0,4'b0001,1'b1,1'b0,1'b1}; // BA
        tbl[19] = '{1'b1,1'b1,1'b1,4'b1111,1'b0,4'b0000,1'b0,4'b0001,1'b0,1'b0,1'b1}; // stall in DSLOT
        tbl[20] = '{1'b1,1'b0,1'b0,4'b0000,1'b0,4'b0000,1'b0,4'b0001,1'b0,1'b0,1'b0};

        // Reset state, visible while reset is still asserted.
        #12;
        check("reset_state", 32'(obs()), 32'(8'b0000_0_0_0_0));
        @(negedge clk);
        reset_n = 1'b1;

        // Vector table.
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].iv, tbl[i].st, tbl[i].we, tbl[i].alu,
                  tbl[i].br, tbl[i].c, tbl[i].ab);
            check($sformatf("vec%0d", i), 32'(obs()),
                  32'({tbl[i].psr, tbl[i].psr[1], tbl[i].t, tbl[i].an, tbl[i].ds}));
        end

        // Same-cycle cc write + BL: bypass copy sees N^V=1, stored copy sees 0.
        do_reset();
        drive(1, 0, 1, 4'b1000, 1, 4'b0011, 0);
        check("bypass_taken", 32'(branch_taken), 32'd1);
        check("nobypass_taken", 32'({nb_taken, nb_n, nb_dslot}), 32'(3'b0_1_1));
        drive(1, 0, 0, 4'b0000, 0, 4'b0000, 0);

        // Stall held in ANNUL: state and flags frozen, then one squashed issue.
        drive(1, 0, 0, 4'b0000, 1, 4'b0001, 1);   // BE,a with Z=0 -> annul
        check("annul_enter", 32'({annul, branch_taken}), 32'(2'b10));
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1, 4'b1111, 1, 4'b1000, 0);
            check($sformatf("annul_stall%0d", k), 32'(obs()), 32'(8'b1000_0_0_1_0));
        end
        drive(1, 0, 1, 4'b1111, 1, 4'b1000, 0);
        check("annul_release", 32'(obs()), 32'(8'b1000_0_0_0_0));

        // Async reset in the middle of a DSLOT cycle, no clock edge needed.
        drive(1, 0, 0, 4'b0000, 1, 4'b1000, 0);
        check("pre_reset_dslot", 32'(obs()), 32'(8'b1000_0_1_0_1));
        #2;
        reset_n = 1'b0;
        inst_valid = 1'b0; br_valid = 1'b0; cc_we = 1'b0;
        #1;
        check("async_reset", 32'(obs()), 32'(8'b0000_0_0_0_0));
        @(negedge clk);
        reset_n = 1'b1;

        // Full sweep: stored flags against every condition, both copies.
        for (int f = 0; f < 16; f++) begin
            drive(1, 0, 1, 4'(f), 0, 4'b0000, 0);
            for (int c = 0; c < 16; c++) begin
                drive(1, 0, 0, 4'b0000, 1, 4'(c), 0);
                check($sformatf("sweep_f%0h_c%0h", f, c),
                      32'({branch_taken, nb_taken}),
                      32'({2{exp_taken(4'(c), 4'(f))}}));
                drive(1, 0, 0, 4'b0000, 0, 4'b0000, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
